// File: rtl/zb_phy_pkg.sv
// Shared PHY definitions for the frame builder: FSM state encoding, the SFD
// byte and the CRC-16/KERMIT constants plus a byte-wide CRC update helper.
package zb_phy_pkg;

    localparam int unsigned STATE_W = 3;

    // Frame builder FSM states, in traversal order
    typedef enum logic [STATE_W-1:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        SFD      = 3'd2,
        PHR      = 3'd3,
        PAYLOAD  = 3'd4,
        FCS      = 3'd5,
        DONE     = 3'd6
    } fbState_e;

    localparam logic [7:0]  SFD_BYTE = 8'hA7;
    localparam logic [15:0] CRC_POLY = 16'h8408;  // 0x1021 bit-reflected
    localparam logic [15:0] CRC_INIT = 16'h0000;

    // One byte of reflected CRC-16, data consumed LSB first
    function automatic logic [15:0] crcUpdateByte(input logic [15:0] crc,
                                                  input logic [7:0]  data);
        logic [15:0] c;
        c = crc ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc16_kermit.sv
// CRC-16/KERMIT accumulator, one byte per enabled cycle.
//   inClock  : clock, rising edge
//   inReset  : asynchronous active-low reset (register -> CRC_INIT)
//   inClear  : synchronous restart to CRC_INIT, wins over inEnable
//   inEnable : fold inData into the register this cycle
//   inData   : byte to fold in
//   outCrc   : current CRC register
module crc16_kermit
    import zb_phy_pkg::*;
(
    input  logic        inClock,
    input  logic        inReset,
    input  logic        inClear,
    input  logic        inEnable,
    input  logic [7:0]  inData,
    output logic [15:0] outCrc
);

    // CRC register
    always_ff @(posedge inClock or negedge inReset) begin
        if (!inReset) begin
            outCrc <= CRC_INIT;
        end else if (inClear) begin
            outCrc <= CRC_INIT;
        end else if (inEnable) begin
            outCrc <= crcUpdateByte(outCrc, inData);
        end
    end

endmodule

// File: rtl/zb_frame_builder.sv
// 802.15.4-style PHY frame builder: serialises preamble, SFD, PHR, payload
// and (optionally) FCS into a nibble stream for a downstream FIFO, low nibble
// first. Payload bytes arrive one at a time through a single holding register.
//
// Optional feature: define FRAME_BUILDER_FCS_EN to compile in a CRC-16/KERMIT
// FCS appended after the payload; without it the FCS state is skipped.
//
// Ports:
//   inClock        : clock, rising edge
//   inReset        : asynchronous active-low reset
//   inStart        : frame-start pulse, sampled in IDLE only
//   inLength [6:0] : PSDU length in bytes (FCS included), captured on start
//   inData   [7:0] : payload byte from host
//   inValid        : inData valid
//   outReady       : block accepts inData this cycle
//   inFull         : downstream FIFO almost-full
//   outData  [3:0] : nibble to the FIFO
//   outWriteEnable : FIFO write strobe
//   outBusy        : state is not IDLE
//   outDone        : one-cycle pulse after the last nibble is written
//   outError       : one-cycle pulse on a rejected start
module zb_frame_builder
    import zb_phy_pkg::*;
#(
    parameter int unsigned PREAMBLE_NIBBLES = 8,
    parameter int unsigned MAX_LEN          = 127
) (
    input  logic       inClock,
    input  logic       inReset,
    input  logic       inStart,
    input  logic [6:0] inLength,
    input  logic [7:0] inData,
    input  logic       inValid,
    output logic       outReady,
    input  logic       inFull,
    output logic [3:0] outData,
    output logic       outWriteEnable,
    output logic       outBusy,
    output logic       outDone,
    output logic       outError
);

    localparam int unsigned     PRE_W    = (PREAMBLE_NIBBLES > 1) ? $clog2(PREAMBLE_NIBBLES) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PREAMBLE_NIBBLES - 1);
`ifdef FRAME_BUILDER_FCS_EN
    localparam logic [6:0] MIN_LEN   = 7'd3;
    localparam logic [6:0] FCS_BYTES = 7'd2;
`else
    localparam logic [6:0] MIN_LEN   = 7'd1;
    localparam logic [6:0] FCS_BYTES = 7'd0;
`endif

    fbState_e         state;
    fbState_e         stateNext;
    logic [PRE_W-1:0] preCount;
    logic [1:0]       nibIdx;       // nibble index within SFD/PHR/PAYLOAD byte/FCS
    logic [6:0]       byteCount;    // payload bytes still to be emitted
    logic [6:0]       lenReg;
    logic [7:0]       holdData;
    logic             holdFull;

    logic             lenOk_c;
    logic             startOk_c;
    logic             accept_c;
    logic             emit_c;
    logic             holdFullNext_c;
    logic [3:0]       nibble_c;

`ifdef FRAME_BUILDER_FCS_EN
    logic [15:0]      crcValue;

    // FCS accumulator restarts on each accepted frame and folds in every accepted byte
    crc16_kermit uCrc (
        .inClock  (inClock),
        .inReset  (inReset),
        .inClear  (startOk_c),
        .inEnable (accept_c),
        .inData   (inData),
        .outCrc   (crcValue)
    );
`endif

    // State register
    always_ff @(posedge inClock or negedge inReset) begin
        if (!inReset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic: every state except IDLE/DONE advances on its last emitted nibble
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:     if (startOk_c) stateNext = PREAMBLE;
            PREAMBLE: if (emit_c && preCount == PRE_LAST) stateNext = SFD;
            SFD:      if (emit_c && nibIdx[0]) stateNext = PHR;
            PHR:      if (emit_c && nibIdx[0]) stateNext = PAYLOAD;
            PAYLOAD: begin
                if (emit_c && nibIdx[0] && byteCount == 7'd1) begin
`ifdef FRAME_BUILDER_FCS_EN
                    stateNext = FCS;
`else
                    stateNext = DONE;
`endif
                end
            end
            FCS:      if (emit_c && nibIdx == 2'd3) stateNext = DONE;
            DONE:     stateNext = IDLE;
            default:  stateNext = IDLE;
        endcase
    end

    // Output/qualifier logic: start check, byte acceptance, emit decision and nibble mux
    always_comb begin
        lenOk_c        = 1'b0;
        startOk_c      = 1'b0;
        accept_c       = 1'b0;
        emit_c         = 1'b0;
        holdFullNext_c = holdFull;
        nibble_c       = 4'h0;

        lenOk_c   = (inLength >= MIN_LEN) && (32'(inLength) <= MAX_LEN);
        startOk_c = (state == IDLE) && inStart && lenOk_c;
        accept_c  = inValid && outReady;

        case (state)
            PREAMBLE, SFD, PHR, FCS: emit_c = !inFull;
            PAYLOAD:                 emit_c = !inFull && holdFull;
            default:                 emit_c = 1'b0;
        endcase

        // Holding register frees up once its high nibble goes out
        if (accept_c) begin
            holdFullNext_c = 1'b1;
        end else if (emit_c && state == PAYLOAD && nibIdx[0]) begin
            holdFullNext_c = 1'b0;
        end

        case (state)
            SFD:     nibble_c = nibIdx[0] ? SFD_BYTE[7:4] : SFD_BYTE[3:0];
            PHR:     nibble_c = nibIdx[0] ? {1'b0, lenReg[6:4]} : lenReg[3:0];
            PAYLOAD: nibble_c = nibIdx[0] ? holdData[7:4] : holdData[3:0];
`ifdef FRAME_BUILDER_FCS_EN
            FCS: begin
                case (nibIdx)
                    2'd0:    nibble_c = crcValue[3:0];
                    2'd1:    nibble_c = crcValue[7:4];
                    2'd2:    nibble_c = crcValue[11:8];
                    default: nibble_c = crcValue[15:12];
                endcase
            end
`endif
            default: nibble_c = 4'h0;
        endcase
    end

    // Counters, holding register and registered outputs
    always_ff @(posedge inClock or negedge inReset) begin
        if (!inReset) begin
            preCount       <= '0;
            nibIdx         <= 2'd0;
            byteCount      <= 7'd0;
            lenReg         <= 7'd0;
            holdData       <= 8'h00;
            holdFull       <= 1'b0;
            outReady       <= 1'b0;
            outData        <= 4'h0;
            outWriteEnable <= 1'b0;
            outBusy        <= 1'b0;
            outDone        <= 1'b0;
            outError       <= 1'b0;
        end else begin
            if (startOk_c) begin
                lenReg    <= inLength;
                byteCount <= 7'(inLength - FCS_BYTES);
                preCount  <= '0;
                nibIdx    <= 2'd0;
            end else if (emit_c) begin
                if (stateNext != state) begin
                    nibIdx <= 2'd0;
                end else if (state == PAYLOAD) begin
                    nibIdx <= {1'b0, ~nibIdx[0]};
                end else if (state != PREAMBLE) begin
                    nibIdx <= nibIdx + 2'd1;
                end
                if (state == PREAMBLE) begin
                    preCount <= preCount + PRE_W'(1);
                end
                if (state == PAYLOAD && nibIdx[0]) begin
                    byteCount <= byteCount - 7'd1;
                end
            end

            if (accept_c) begin
                holdData <= inData;
            end
            holdFull <= holdFullNext_c;

            outWriteEnable <= emit_c;
            if (emit_c) begin
                outData <= nibble_c;
            end
            outReady <= (stateNext == PAYLOAD) && !holdFullNext_c;
            outBusy  <= (stateNext != IDLE);
            outDone  <= (state == DONE);
            outError <= (state == IDLE) && inStart && !lenOk_c;
        end
    end

endmodule

// File: tb/tb_zb_frame_builder.sv
// Directed bench for zb_frame_builder: frames are driven by a small host model,
// the nibble stream is captured on the falling edge and compared to hand-built
// expected sequences. The CRC sub-module is also exercised on its own.
module tb_zb_frame_builder;

    logic       inClock  = 1'b0;
    logic       inReset  = 1'b0;
    logic       inStart  = 1'b0;
    logic [6:0] inLength = 7'd0;
    logic [7:0] inData   = 8'h00;
    logic       inValid  = 1'b0;
    logic       inFull   = 1'b0;
    logic       outReady;
    logic [3:0] outData;
    logic       outWriteEnable;
    logic       outBusy;
    logic       outDone;
    logic       outError;

    logic        crcClear  = 1'b0;
    logic        crcEnable = 1'b0;
    logic [7:0]  crcData   = 8'h00;
    logic [15:0] crcOut;

    int total = 0;
    int bad   = 0;

    zb_frame_builder #(.PREAMBLE_NIBBLES(8), .MAX_LEN(127)) dut (
        .inClock        (inClock),
        .inReset        (inReset),
        .inStart        (inStart),
        .inLength       (inLength),
        .inData         (inData),
        .inValid        (inValid),
        .outReady       (outReady),
        .inFull         (inFull),
        .outData        (outData),
        .outWriteEnable (outWriteEnable),
        .outBusy        (outBusy),
        .outDone        (outDone),
        .outError       (outError)
    );

    crc16_kermit uCrc (
        .inClock  (inClock),
        .inReset  (inReset),
        .inClear  (crcClear),
        .inEnable (crcEnable),
        .inData   (crcData),
        .outCrc   (crcOut)
    );

    always #5 inClock = ~inClock;

    // Cycle stamp and output capture
    int         cyc = 0;
    logic [3:0] wrQ[$];
    int         wcQ[$];
    int         doneCnt = 0;
    int         errCnt  = 0;
    int         busyCnt = 0;

    always @(posedge inClock) cyc <= cyc + 1;

    always @(negedge inClock) begin
        if (outWriteEnable) begin
            wrQ.push_back(outData);
            wcQ.push_back(cyc);
        end
        if (outDone)  doneCnt++;
        if (outError) errCnt++;
        if (outBusy)  busyCnt++;
    end

    // Host model knobs
    logic [7:0] payBuf[16];
    int fullFrom = -1, fullLen = 0, gapAfter = -1, gapLen = 0, abortAfter = -1, spurAt = -1;
    int startCyc, gapStartCyc, gapReadyCnt;
    bit timedOut;

    task automatic tick();
        @(negedge inClock);
        #1;
    endtask

    task automatic clearCapture();
        wrQ.delete();
        wcQ.delete();
        doneCnt = 0;
        errCnt  = 0;
        busyCnt = 0;
    endtask

    // Start one frame and feed nPay bytes until outDone (or abort / budget)
    task automatic runFrame(input int len, input int nPay);
        int acc = 0;
        int gapLeft;
        int rel;
        bit finished = 0;
        clearCapture();
        gapLeft     = gapLen;
        gapReadyCnt = 0;
        gapStartCyc = -1;
        timedOut    = 0;
        inStart  = 1'b1;
        inLength = 7'(len);
        startCyc = cyc;
        tick();
        for (int b = 0; b < 300 && !finished; b++) begin
            rel      = cyc - startCyc;
            inFull   = (fullFrom >= 0 && rel >= fullFrom && rel < fullFrom + fullLen);
            inStart  = (rel == spurAt);
            if (rel == spurAt) inLength = 7'd0;
            if (acc == gapAfter && gapLeft > 0 && (gapLeft < gapLen || outReady)) begin
                if (gapLeft == gapLen) gapStartCyc = cyc;
                if (outReady) gapReadyCnt++;
                inValid = 1'b0;
                gapLeft--;
            end else if (outReady && acc < nPay) begin
                inValid = 1'b1;
                inData  = payBuf[acc];
                acc++;
            end else begin
                inValid = 1'b0;
            end
            tick();
            if (doneCnt > 0 || (abortAfter >= 0 && acc == abortAfter)) finished = 1;
        end
        inValid = 1'b0;
        inStart = 1'b0;
        inFull  = 1'b0;
        if (!finished) timedOut = 1;
        if (abortAfter < 0) repeat (3) tick();
        fullFrom = -1; fullLen = 0; gapAfter = -1; gapLen = 0; abortAfter = -1; spurAt = -1;
    endtask

    task automatic test_reset();
        repeat (2) tick();
        total++; if (outReady !== 1'b0)       begin bad++; $display("FAIL reset_ready: got %b want 0", outReady); end
        total++; if (outData !== 4'h0)        begin bad++; $display("FAIL reset_data: got %h want 0", outData); end
        total++; if (outWriteEnable !== 1'b0) begin bad++; $display("FAIL reset_we: got %b want 0", outWriteEnable); end
        total++; if (outBusy !== 1'b0)        begin bad++; $display("FAIL reset_busy: got %b want 0", outBusy); end
        total++; if (outDone !== 1'b0)        begin bad++; $display("FAIL reset_done: got %b want 0", outDone); end
        total++; if (outError !== 1'b0)       begin bad++; $display("FAIL reset_error: got %b want 0", outError); end
        inReset = 1'b1;
        repeat (2) tick();
        total++; if (outBusy !== 1'b0)        begin bad++; $display("FAIL idle_busy: got %b want 0", outBusy); end
    endtask

    task automatic test_crc_unit();
        crcClear = 1'b1; tick(); crcClear = 1'b0;
        crcEnable = 1'b1;
        for (int i = 0; i < 9; i++) begin
            crcData = 8'h31 + 8'(i);
            tick();
        end
        crcEnable = 1'b0;
        total++; if (crcOut !== 16'h2189) begin bad++; $display("FAIL crc_check: got %h want 2189", crcOut); end
        crcClear = 1'b1; tick(); crcClear = 1'b0;
        total++; if (crcOut !== 16'h0000) begin bad++; $display("FAIL crc_clear: got %h want 0000", crcOut); end
    endtask

    task automatic test_bad_len(input logic [6:0] len, input string name);
        tick();
        clearCapture();
        inStart = 1'b1; inLength = len; tick(); inStart = 1'b0;
        repeat (5) tick();
        total++; if (errCnt !== 1)      begin bad++; $display("FAIL %s_error_cycles: got %0d want 1", name, errCnt); end
        total++; if (wrQ.size() !== 0)  begin bad++; $display("FAIL %s_writes: got %0d want 0", name, wrQ.size()); end
        total++; if (busyCnt !== 0)     begin bad++; $display("FAIL %s_busy_cycles: got %0d want 0", name, busyCnt); end
    endtask

`ifdef FRAME_BUILDER_FCS_EN
    task automatic test_fcs();
        logic [3:0] exp[34] = '{4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0, 4'h7,4'hA, 4'hB,4'h0,
                                4'h1,4'h3, 4'h2,4'h3, 4'h3,4'h3, 4'h4,4'h3, 4'h5,4'h3,
                                4'h6,4'h3, 4'h7,4'h3, 4'h8,4'h3, 4'h9,4'h3,
                                4'h9,4'h8,4'h1,4'h2};
        for (int i = 0; i < 9; i++) payBuf[i] = 8'h31 + 8'(i);
        runFrame(11, 9);
        total++; if (timedOut !== 1'b0)   begin bad++; $display("FAIL fcs_timeout: got %b want 0", timedOut); end
        total++; if (wrQ.size() !== 34)   begin bad++; $display("FAIL fcs_count: got %0d want 34", wrQ.size()); end
        for (int i = 0; i < 34 && i < wrQ.size(); i++) begin
            total++; if (wrQ[i] !== exp[i]) begin bad++; $display("FAIL fcs_nibble[%0d]: got %h want %h", i, wrQ[i], exp[i]); end
        end
        total++; if (doneCnt !== 1)       begin bad++; $display("FAIL fcs_done_cycles: got %0d want 1", doneCnt); end
    endtask
`else
    task automatic test_basic(input string name);
        logic [3:0] exp[14] = '{4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0, 4'h7,4'hA, 4'h1,4'h0, 4'hA,4'h5};
        payBuf[0] = 8'h5A;
        spurAt = 4;
        runFrame(1, 1);
        total++; if (timedOut !== 1'b0)   begin bad++; $display("FAIL %s_timeout: got %b want 0", name, timedOut); end
        total++; if (wrQ.size() !== 14)   begin bad++; $display("FAIL %s_count: got %0d want 14", name, wrQ.size()); end
        for (int i = 0; i < 14 && i < wrQ.size(); i++) begin
            total++; if (wrQ[i] !== exp[i]) begin bad++; $display("FAIL %s_nibble[%0d]: got %h want %h", name, i, wrQ[i], exp[i]); end
        end
        if (wcQ.size() > 0) begin
            total++; if (wcQ[0] !== startCyc + 2) begin bad++; $display("FAIL %s_first_write_cycle: got %0d want %0d", name, wcQ[0], startCyc + 2); end
        end
        total++; if (doneCnt !== 1)       begin bad++; $display("FAIL %s_done_cycles: got %0d want 1", name, doneCnt); end
        total++; if (errCnt !== 0)        begin bad++; $display("FAIL %s_busy_start_error: got %0d want 0", name, errCnt); end
        total++; if (outBusy !== 1'b0)    begin bad++; $display("FAIL %s_busy_after: got %b want 0", name, outBusy); end
    endtask

    task automatic test_full_hold();
        logic [3:0] exp[16] = '{4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0, 4'h7,4'hA, 4'h2,4'h0,
                                4'hC,4'h3, 4'h1,4'hE};
        int inWin = 0;
        payBuf[0] = 8'h3C; payBuf[1] = 8'hE1;
        fullFrom = 3; fullLen = 5;
        runFrame(2, 2);
        foreach (wcQ[i]) if (wcQ[i] >= startCyc + 4 && wcQ[i] <= startCyc + 8) inWin++;
        total++; if (timedOut !== 1'b0)   begin bad++; $display("FAIL full_timeout: got %b want 0", timedOut); end
        total++; if (inWin !== 0)         begin bad++; $display("FAIL full_writes_in_hold: got %0d want 0", inWin); end
        total++; if (wrQ.size() !== 16)   begin bad++; $display("FAIL full_count: got %0d want 16", wrQ.size()); end
        for (int i = 0; i < 16 && i < wrQ.size(); i++) begin
            total++; if (wrQ[i] !== exp[i]) begin bad++; $display("FAIL full_nibble[%0d]: got %h want %h", i, wrQ[i], exp[i]); end
        end
    endtask

    task automatic test_payload_stall();
        logic [3:0] exp[18] = '{4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0,4'h0, 4'h7,4'hA, 4'h3,4'h0,
                                4'h2,4'h1, 4'h4,4'h3, 4'h6,4'h5};
        int inWin = 0;
        payBuf[0] = 8'h12; payBuf[1] = 8'h34; payBuf[2] = 8'h56;
        gapAfter = 1; gapLen = 4;
        runFrame(3, 3);
        foreach (wcQ[i]) if (wcQ[i] >= gapStartCyc + 1 && wcQ[i] <= gapStartCyc + 4) inWin++;
        total++; if (timedOut !== 1'b0)   begin bad++; $display("FAIL stall_timeout: got %b want 0", timedOut); end
        total++; if (gapReadyCnt !== 4)   begin bad++; $display("FAIL stall_ready_cycles: got %0d want 4", gapReadyCnt); end
        total++; if (inWin !== 0)         begin bad++; $display("FAIL stall_writes_in_gap: got %0d want 0", inWin); end
        total++; if (wrQ.size() !== 18)   begin bad++; $display("FAIL stall_count: got %0d want 18", wrQ.size()); end
        for (int i = 0; i < 18 && i < wrQ.size(); i++) begin
            total++; if (wrQ[i] !== exp[i]) begin bad++; $display("FAIL stall_nibble[%0d]: got %h want %h", i, wrQ[i], exp[i]); end
        end
        total++; if (doneCnt !== 1)       begin bad++; $display("FAIL stall_done_cycles: got %0d want 1", doneCnt); end
    endtask

    task automatic test_reset_mid();
        logic [5:0] outs;
        payBuf[0] = 8'h11; payBuf[1] = 8'h22; payBuf[2] = 8'h33; payBuf[3] = 8'h44;
        abortAfter = 2;
        runFrame(4, 4);
        total++; if (outBusy !== 1'b1)    begin bad++; $display("FAIL midreset_busy_before: got %b want 1", outBusy); end
        #2;
        inReset = 1'b0;
        #1;
        outs = {outReady, outWriteEnable, outBusy, outDone, outError, |outData};
        total++; if (outs !== 6'b0)       begin bad++; $display("FAIL midreset_outputs: got %b want 000000", outs); end
        tick();
        inReset = 1'b1;
        tick();
        total++; if (outBusy !== 1'b0)    begin bad++; $display("FAIL midreset_idle: got %b want 0", outBusy); end
        test_basic("after_reset");
    endtask
`endif

    initial begin
        test_reset();
        test_crc_unit();
        test_bad_len(7'd0, "len0");
`ifdef FRAME_BUILDER_FCS_EN
        test_bad_len(7'd2, "len2");
        test_fcs();
`else
        test_basic("basic");
        test_full_hold();
        test_payload_stall();
        test_reset_mid();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
